// File: rtl/tb_tcdm_banked_model.sv
// Word-interleaved multi-bank TCDM simulation model: per-bank round-robin arbitration,
// fixed-latency in-order responses, global grant enable and optional LFSR grant stalls.
module tb_tcdm_banked_model #(
  parameter int unsigned MP          = 4,
  parameter int unsigned NB          = 8,
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 32,
  parameter int unsigned MEMORY_SIZE = 65536,
  parameter int unsigned LATENCY     = 1,
  parameter bit          STALL_EN    = 1'b0,
  parameter logic [31:0] STALL_SEED  = 32'hACE1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [MP-1:0]             tcdm_req_i,
  output logic [MP-1:0]             tcdm_gnt_o,
  input  logic [MP-1:0][AW-1:0]     tcdm_add_i,
  input  logic [MP-1:0]             tcdm_wen_i,
  input  logic [MP-1:0][DW/8-1:0]   tcdm_be_i,
  input  logic [MP-1:0][DW-1:0]     tcdm_data_i,
  output logic [MP-1:0][DW-1:0]     tcdm_r_data_o,
  output logic [MP-1:0]             tcdm_r_valid_o
);
  localparam int unsigned BE_W   = DW / 8;
  localparam int unsigned BANK_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned PTR_W  = (MP > 1) ? $clog2(MP) : 1;
  localparam int unsigned ROWS   = MEMORY_SIZE / (NB * BE_W);
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [DW-1:0]     mem [NB][ROWS];
  logic [AW-1:0]     word_idx  [MP];
  logic [BANK_W-1:0] bank_of   [MP];
  logic [ROW_W-1:0]  row_of    [MP];
  logic [DW-1:0]     resp_word [MP];
  logic [15:0]       lfsr_q;
  logic [MP-1:0]     stall;
  logic [MP-1:0]     cand;
  logic [MP-1:0]     gnt;
  logic [PTR_W-1:0]  arb_idx;
  logic [NB-1:0]     win_vld;
  logic [PTR_W-1:0]  win_idx  [NB];
  logic [PTR_W-1:0]  rr_ptr_q [NB];
  logic [MP-1:0]     pipe_vld_q  [LATENCY];
  logic [DW-1:0]     pipe_data_q [MP][LATENCY];

  // Address decode and the word each port would see: stored word, with write bytes merged in
  always_comb begin
    for (int unsigned p = 0; p < MP; p++) begin
      word_idx[p]  = (tcdm_add_i[p] % AW'(MEMORY_SIZE)) / AW'(BE_W);
      bank_of[p]   = BANK_W'(word_idx[p] % AW'(NB));
      row_of[p]    = ROW_W'(word_idx[p] / AW'(NB));
      resp_word[p] = mem[bank_of[p]][row_of[p]];
      if (!tcdm_wen_i[p]) begin
        for (int unsigned j = 0; j < BE_W; j++) begin
          if (tcdm_be_i[p][j]) resp_word[p][8*j +: 8] = tcdm_data_i[p][8*j +: 8];
        end
      end
    end
  end

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= STALL_SEED[15:0];
    end else if (STALL_EN) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < MP; p++) begin
      stall[p] = STALL_EN && lfsr_q[4'(p % 16)];
    end
  end

  assign cand = tcdm_req_i & ~stall & {MP{enable_i & ~rst_i}};

  // Per bank: first eligible port at or after the round-robin pointer wins
  always_comb begin
    gnt     = '0;
    arb_idx = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      win_vld[b] = 1'b0;
      win_idx[b] = '0;
      for (int unsigned k = 0; k < MP; k++) begin
        arb_idx = PTR_W'((32'(rr_ptr_q[b]) + k) % MP);
        if (!win_vld[b] && cand[arb_idx] && bank_of[arb_idx] == BANK_W'(b)) begin
          win_vld[b]   = 1'b1;
          win_idx[b]   = arb_idx;
          gnt[arb_idx] = 1'b1;
        end
      end
    end
  end

  assign tcdm_gnt_o = gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned b = 0; b < NB; b++) rr_ptr_q[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (win_vld[b]) rr_ptr_q[b] <= PTR_W'((32'(win_idx[b]) + 1) % MP);
      end
    end
  end

  // Storage is deliberately not reset so preloaded contents survive a reset
  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < MP; p++) begin
      if (gnt[p] && !tcdm_wen_i[p]) mem[bank_of[p]][row_of[p]] <= resp_word[p];
    end
  end

  // Response shift pipeline; data is zero in idle slots
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < LATENCY; s++) begin
        pipe_vld_q[s] <= '0;
        for (int unsigned p = 0; p < MP; p++) pipe_data_q[p][s] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= gnt;
      for (int unsigned p = 0; p < MP; p++) pipe_data_q[p][0] <= gnt[p] ? resp_word[p] : '0;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        for (int unsigned p = 0; p < MP; p++) pipe_data_q[p][s] <= pipe_data_q[p][s-1];
      end
    end
  end

  assign tcdm_r_valid_o = pipe_vld_q[LATENCY-1];

  always_comb begin
    for (int unsigned p = 0; p < MP; p++) tcdm_r_data_o[p] = pipe_data_q[p][LATENCY-1];
  end

endmodule

// File: tb/tb_tb_tcdm_banked_model.sv
// Scoreboard bench for tb_tcdm_banked_model: three instances (latency 1, latency 3,
// latency 4 with stalls) checked against a byte-level reference memory.
module tb_tb_tcdm_banked_model;
  localparam int unsigned NI = 3;
  localparam int unsigned MP = 4;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] data;
  } exp_t;

  logic                 clk;
  logic                 rst    [NI];
  logic                 en     [NI];
  logic [MP-1:0]        req    [NI];
  logic [MP-1:0]        gnt    [NI];
  logic [MP-1:0]        wen    [NI];
  logic [MP-1:0]        rvalid [NI];
  logic [MP-1:0][31:0]  add    [NI];
  logic [MP-1:0][31:0]  wdata  [NI];
  logic [MP-1:0][31:0]  rdata  [NI];
  logic [MP-1:0][3:0]   be     [NI];

  int unsigned cyc;
  int unsigned chk_cnt;
  int unsigned pass_cnt;
  int unsigned gnt_cnt [NI];
  int unsigned rsp_cnt [NI];
  exp_t        sb_q    [NI][MP][$];
  logic [31:0] model   [NI][16384];

  tb_tcdm_banked_model #(.MP(4), .NB(8), .DW(32), .AW(32), .MEMORY_SIZE(65536),
    .LATENCY(1), .STALL_EN(1'b0), .STALL_SEED(32'hACE1)) u_lat1 (
    .clk_i(clk), .rst_i(rst[0]), .enable_i(en[0]), .tcdm_req_i(req[0]), .tcdm_gnt_o(gnt[0]),
    .tcdm_add_i(add[0]), .tcdm_wen_i(wen[0]), .tcdm_be_i(be[0]), .tcdm_data_i(wdata[0]),
    .tcdm_r_data_o(rdata[0]), .tcdm_r_valid_o(rvalid[0]));

  tb_tcdm_banked_model #(.MP(4), .NB(8), .DW(32), .AW(32), .MEMORY_SIZE(65536),
    .LATENCY(3), .STALL_EN(1'b0), .STALL_SEED(32'hACE1)) u_lat3 (
    .clk_i(clk), .rst_i(rst[1]), .enable_i(en[1]), .tcdm_req_i(req[1]), .tcdm_gnt_o(gnt[1]),
    .tcdm_add_i(add[1]), .tcdm_wen_i(wen[1]), .tcdm_be_i(be[1]), .tcdm_data_i(wdata[1]),
    .tcdm_r_data_o(rdata[1]), .tcdm_r_valid_o(rvalid[1]));

  tb_tcdm_banked_model #(.MP(4), .NB(8), .DW(32), .AW(32), .MEMORY_SIZE(65536),
    .LATENCY(4), .STALL_EN(1'b1), .STALL_SEED(32'hACE1)) u_stall (
    .clk_i(clk), .rst_i(rst[2]), .enable_i(en[2]), .tcdm_req_i(req[2]), .tcdm_gnt_o(gnt[2]),
    .tcdm_add_i(add[2]), .tcdm_wen_i(wen[2]), .tcdm_be_i(be[2]), .tcdm_data_i(wdata[2]),
    .tcdm_r_data_o(rdata[2]), .tcdm_r_valid_o(rvalid[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: run still active at cycle %0d, required to have finished", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic int unsigned lat_of(input int unsigned k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return 32'((a % 32'd65536) >> 2);
  endfunction

  function automatic int unsigned bank(input logic [31:0] a);
    return widx(a) % 8;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Scoreboard: push expected response on each grant, pop and compare on each r_valid
  always @(negedge clk) begin
    int unsigned w;
    logic [31:0] e;
    exp_t        ent;
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < MP; p++) begin
        if (rst[k]) begin
          sb_q[k][p].delete();
          check_eq($sformatf("rst_rvalid_i%0d_p%0d", k, p), 32'(rvalid[k][p]), 32'd0);
          check_eq($sformatf("rst_gnt_i%0d_p%0d", k, p), 32'(gnt[k][p]), 32'd0);
        end else begin
          if (rvalid[k][p]) begin
            rsp_cnt[k]++;
            check_eq($sformatf("rsp_expected_i%0d_p%0d", k, p), 32'(sb_q[k][p].size() > 0), 32'd1);
            if (sb_q[k][p].size() > 0) begin
              ent = sb_q[k][p].pop_front();
              check_eq($sformatf("rsp_cycle_i%0d_p%0d", k, p), cyc, ent.due);
              check_eq($sformatf("rsp_data_i%0d_p%0d", k, p), rdata[k][p], ent.data);
            end
          end else begin
            check_eq($sformatf("idle_data_i%0d_p%0d", k, p), rdata[k][p], 32'd0);
            if (sb_q[k][p].size() > 0 && sb_q[k][p][0].due <= cyc) begin
              check_eq($sformatf("rsp_missing_i%0d_p%0d", k, p), 32'(rvalid[k][p]), 32'd1);
              void'(sb_q[k][p].pop_front());
            end
          end
          if (gnt[k][p]) begin
            gnt_cnt[k]++;
            check_eq($sformatf("gnt_needs_req_i%0d_p%0d", k, p), 32'(req[k][p]), 32'd1);
            w = widx(add[k][p]);
            e = model[k][w];
            if (!wen[k][p]) begin
              for (int j = 0; j < 4; j++) begin
                if (be[k][p][j]) e[8*j +: 8] = wdata[k][p][8*j +: 8];
              end
              model[k][w] = e;
            end
            ent.due  = cyc + lat_of(k);
            ent.data = e;
            sb_q[k][p].push_back(ent);
          end
        end
      end
    end
  end

  // Drive one request, hold it until granted (bounded), return grant cycle and wait count
  task automatic op(input int k, input int p, input logic [31:0] a, input logic rd,
                    input logic [3:0] b, input logic [31:0] d,
                    output int unsigned gcyc, output int unsigned waited);
    req[k][p]   = 1'b1;
    add[k][p]   = a;
    wen[k][p]   = rd;
    be[k][p]    = b;
    wdata[k][p] = d;
    waited = 0;
    @(negedge clk);
    while (!gnt[k][p] && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!gnt[k][p]) check_eq($sformatf("gnt_timeout_i%0d_p%0d", k, p), 32'(gnt[k][p]), 32'd1);
    gcyc = cyc;
    @(posedge clk);
    #1;
    req[k][p] = 1'b0;
  endtask

  task automatic expect_rsp(input int k, input int p, input int unsigned gcyc,
                            input logic [31:0] exp, input string tag);
    do @(negedge clk); while (cyc < gcyc + lat_of(k));
    check_eq({tag, "_valid"}, 32'(rvalid[k][p]), 32'd1);
    check_eq({tag, "_data"}, rdata[k][p], exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned g;
    int unsigned wt;
    int unsigned n_gnt;
    int unsigned stall_cnt;
    int unsigned pend;
    int          r;
    logic        rival;
    cyc = 0; chk_cnt = 0; pass_cnt = 0;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; en[k] = 1'b1; req[k] = '0; add[k] = '0; wen[k] = '1;
      be[k] = '0; wdata[k] = '0; gnt_cnt[k] = 0; rsp_cnt[k] = 0;
    end
    req[0] = 4'b0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_gnt", 32'(gnt[0]), 32'd0);
    check_eq("reset_rvalid", 32'(rvalid[0]), 32'd0);
    check_eq("reset_rdata", rdata[0][0], 32'd0);
    @(posedge clk);
    #1;
    req[0] = '0;
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;

    // Single-port write then read, latency 1
    op(0, 0, 32'h100, 1'b0, 4'hF, 32'hDEADBEEF, g, wt);
    check_eq("wr_gnt_wait", wt, 32'd0);
    expect_rsp(0, 0, g, 32'hDEADBEEF, "wr_rsp");
    op(0, 0, 32'h100, 1'b1, 4'h0, 32'h0, g, wt);
    check_eq("rd_gnt_wait", wt, 32'd0);
    expect_rsp(0, 0, g, 32'hDEADBEEF, "rd_rsp");

    // Partial write, unaligned address and address wrap
    op(0, 0, 32'h40, 1'b0, 4'hF, 32'h11223344, g, wt);
    expect_rsp(0, 0, g, 32'h11223344, "pre_rsp");
    op(0, 0, 32'h40, 1'b0, 4'b0101, 32'hAABBCCDD, g, wt);
    expect_rsp(0, 0, g, 32'h11BB33DD, "pwr_rsp");
    op(0, 0, 32'h40, 1'b1, 4'h0, 32'h0, g, wt);
    expect_rsp(0, 0, g, 32'h11BB33DD, "prd_rsp");
    op(0, 0, 32'h43, 1'b1, 4'h0, 32'h0, g, wt);
    expect_rsp(0, 0, g, 32'h11BB33DD, "unaligned_rsp");
    op(0, 0, 32'h10040, 1'b1, 4'h0, 32'h0, g, wt);
    expect_rsp(0, 0, g, 32'h11BB33DD, "wrap_rsp");

    // Bank conflict after a reset that restarts the pointers
    for (int i = 0; i < 4; i++) begin
      op(0, 0, 32'(4 * i), 1'b0, 4'hF, 32'hA0A00000 + 32'(i), g, wt);
      expect_rsp(0, 0, g, 32'hA0A00000 + 32'(i), "conf_pre");
    end
    rst[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    for (int p = 0; p < MP; p++) begin add[0][p] = 32'h0; wen[0][p] = 1'b1; end
    req[0] = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("arb_order", 32'(gnt[0]), 32'd1 << c);
      @(posedge clk);
      #1;
    end
    req[0] = '0;
    for (int p = 0; p < MP; p++) add[0][p] = 32'(4 * p);
    req[0] = 4'hF;
    @(negedge clk);
    check_eq("parallel_gnt", 32'(gnt[0]), 32'hF);
    @(posedge clk);
    #1;
    req[0] = '0;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure through the global enable
    en[0] = 1'b0;
    req[0][1] = 1'b1; add[0][1] = 32'h100; wen[0][1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("bp_gnt", 32'(gnt[0]), 32'd0);
      check_eq("bp_rvalid", 32'(rvalid[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    en[0] = 1'b1;
    op(0, 1, 32'h100, 1'b1, 4'h0, 32'h0, g, wt);
    check_eq("bp_release_wait", wt, 32'd0);
    expect_rsp(0, 1, g, 32'hDEADBEEF, "bp_rsp");

    // Latency 3: back-to-back reads over 8 consecutive words
    for (int i = 0; i < 8; i++) begin
      op(1, 2, 32'h200 + 32'(4 * i), 1'b0, 4'hF, 32'hC0DE0000 + 32'(i), g, wt);
      expect_rsp(1, 2, g, 32'hC0DE0000 + 32'(i), "l3_pre");
    end
    req[1][2] = 1'b1; wen[1][2] = 1'b1; add[1][2] = 32'h200;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n < 8) check_eq("b2b_gnt", 32'(gnt[1][2]), 32'd1);
      if (n >= 3 && n < 11) begin
        check_eq("b2b_rvalid", 32'(rvalid[1][2]), 32'd1);
        check_eq("b2b_data", rdata[1][2], 32'hC0DE0000 + 32'(n - 3));
      end else begin
        check_eq("b2b_rvalid_idle", 32'(rvalid[1][2]), 32'd0);
      end
      @(posedge clk);
      #1;
      if (n < 7) add[1][2] = 32'h200 + 32'(4 * (n + 1));
      else req[1][2] = 1'b0;
    end

    // Random traffic with stall injection
    for (int i = 0; i < 64; i++) begin
      op(2, i % 4, 32'h1000 + 32'(4 * i), 1'b0, 4'hF, $urandom, g, wt);
    end
    n_gnt = 0;
    stall_cnt = 0;
    for (int c = 0; c < 6000 && n_gnt < 1000; c++) begin
      for (int p = 0; p < MP; p++) begin
        r = int'($urandom_range(0, 99));
        req[2][p]   = (r < 70);
        wen[2][p]   = (r >= 14);
        be[2][p]    = 4'($urandom);
        wdata[2][p] = $urandom;
        add[2][p]   = 32'h1000 + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3))
                    + (($urandom_range(0, 3) == 0) ? 32'h10000 * 32'($urandom_range(1, 7)) : 32'd0);
      end
      @(negedge clk);
      for (int p = 0; p < MP; p++) begin
        if (gnt[2][p]) n_gnt++;
        if (req[2][p] && !gnt[2][p]) begin
          rival = 1'b0;
          for (int q = 0; q < MP; q++) begin
            if (q != p && gnt[2][q] && bank(add[2][q]) == bank(add[2][p])) rival = 1'b1;
          end
          if (!rival) stall_cnt++;
        end
      end
      @(posedge clk);
      #1;
    end
    req[2] = '0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    pend = 0;
    for (int p = 0; p < MP; p++) pend += 32'(sb_q[2][p].size());
    check_eq("rand_grants", 32'(n_gnt >= 1000), 32'd1);
    check_eq("stall_seen", 32'(stall_cnt > 0), 32'd1);
    check_eq("gnt_vs_rsp", rsp_cnt[2], gnt_cnt[2]);
    check_eq("sb_drained", pend, 32'd0);
    @(posedge clk);
    #1;

    // Reset two cycles after a read grant drops its response, memory survives
    op(2, 0, 32'h2000, 1'b0, 4'hF, 32'h5A5A1234, g, wt);
    expect_rsp(2, 0, g, 32'h5A5A1234, "mid_pre");
    op(2, 0, 32'h2000, 1'b1, 4'h0, 32'h0, g, wt);
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_eq("rst_drop_rvalid", 32'(rvalid[2][0]), 32'd0);
      @(posedge clk);
      #1;
    end
    op(2, 0, 32'h2000, 1'b1, 4'h0, 32'h0, g, wt);
    expect_rsp(2, 0, g, 32'h5A5A1234, "rst_mem_kept");
    op(2, 1, 32'h1000, 1'b1, 4'h0, 32'h0, g, wt);
    expect_rsp(2, 1, g, model[2][widx(32'h1000)], "rst_mem_kept2");

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
